// File: rtl/instruction_decode_stage.sv
// Instruction decode stage: register file, branch/jump resolution, hazard
// detection and the ID/EX pipeline register.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   instructionFetchReg        IF/ID register {instruction, pc}
//   wbWrite/wbAddr/wbData      register-file write-back port
//   memRegWrite/memDest        EX/MEM destination info for branch hazards
//   branchResult/branchAddrs   fetch redirect (combinational)
//   regStall/muxStall          hold IF/ID and PC (combinational)
//   ex*                        registered ID/EX outputs
module instruction_decode_stage #(
    parameter int unsigned REG_COUNT = 32,
    parameter int unsigned DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [63:0]       instructionFetchReg,
    input  logic              wbWrite,
    input  logic [4:0]        wbAddr,
    input  logic [DATA_W-1:0] wbData,
    input  logic              memRegWrite,
    input  logic [4:0]        memDest,
    output logic              branchResult,
    output logic [31:0]       branchAddrs,
    output logic              regStall,
    output logic              muxStall,
    output logic              exRegWrite,
    output logic              exMemRead,
    output logic              exMemWrite,
    output logic              exMemToReg,
    output logic              exAluSrc,
    output logic [2:0]        exAluCtrl,
    output logic [DATA_W-1:0] exRsData,
    output logic [DATA_W-1:0] exRtData,
    output logic [DATA_W-1:0] exImm,
    output logic [4:0]        exRs,
    output logic [4:0]        exRt,
    output logic [4:0]        exDest,
    output logic [31:0]       exPc
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    typedef struct packed {
        logic              regWrite;
        logic              memRead;
        logic              memWrite;
        logic              memToReg;
        logic              aluSrc;
        logic [2:0]        aluCtrl;
        logic [DATA_W-1:0] rsData;
        logic [DATA_W-1:0] rtData;
        logic [DATA_W-1:0] imm;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        dest;
        logic [31:0]       pc;
    } idEx_t;

    logic [31:0]       instr;
    logic [31:0]       pc;
    logic [5:0]        op;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [5:0]        funct;
    logic [DATA_W-1:0] immExt;
    logic [31:0]       pcPlus4;

    assign instr   = instructionFetchReg[63:32];
    assign pc      = instructionFetchReg[31:0];
    assign op      = instr[31:26];
    assign rs      = instr[25:21];
    assign rt      = instr[20:16];
    assign rd      = instr[15:11];
    assign funct   = instr[5:0];
    assign immExt  = {{(DATA_W-16){instr[15]}}, instr[15:0]};
    assign pcPlus4 = pc + 32'd4;

    logic [DATA_W-1:0] regFile [REG_COUNT];
    logic [DATA_W-1:0] rsData;
    logic [DATA_W-1:0] rtData;

    // Register file storage; r0 is never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(REG_COUNT); i++) regFile[i] <= '0;
        end else if (wbWrite && wbAddr != 5'd0) begin
            regFile[wbAddr] <= wbData;
        end
    end

    // Read ports with write-first bypass of the write-back value
    always_comb begin
        rsData = '0;
        rtData = '0;
        if (rs != 5'd0) rsData = (wbWrite && wbAddr == rs) ? wbData : regFile[rs];
        if (rt != 5'd0) rtData = (wbWrite && wbAddr == rt) ? wbData : regFile[rt];
    end

    idEx_t dec;
    idEx_t idEx;
    logic  decValid;

    // Opcode/funct decode into the ID/EX control word
    always_comb begin
        dec      = '0;
        decValid = 1'b1;
        unique case (op)
            OP_RTYPE: begin
                dec.regWrite = 1'b1;
                dec.dest     = rd;
                unique case (funct)
                    6'h20:   dec.aluCtrl = ALU_ADD;
                    6'h22:   dec.aluCtrl = ALU_SUB;
                    6'h24:   dec.aluCtrl = ALU_AND;
                    6'h25:   dec.aluCtrl = ALU_OR;
                    6'h2A:   dec.aluCtrl = ALU_SLT;
                    default: decValid    = 1'b0;
                endcase
            end
            OP_ADDI: begin
                dec.regWrite = 1'b1;
                dec.aluSrc   = 1'b1;
                dec.dest     = rt;
            end
            OP_LW: begin
                dec.regWrite = 1'b1;
                dec.aluSrc   = 1'b1;
                dec.memRead  = 1'b1;
                dec.memToReg = 1'b1;
                dec.dest     = rt;
            end
            OP_SW: begin
                dec.aluSrc   = 1'b1;
                dec.memWrite = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_J: ;
            default: decValid = 1'b0;
        endcase
        // A write to r0 is meaningless, so the all-zero word becomes a NOP
        if (dec.dest == 5'd0) dec.regWrite = 1'b0;
        dec.rsData = rsData;
        dec.rtData = rtData;
        dec.imm    = immExt;
        dec.rs     = rs;
        dec.rt     = rt;
        dec.pc     = pc;
        if (!decValid) dec = '0;
    end

    logic isBranch;
    logic loadUse;
    logic branchHazard;
    logic stall;

    assign isBranch = (op == OP_BEQ) || (op == OP_BNE);

    // Hazards: no forwarding into ID, so branches wait for producers to retire
    always_comb begin
        loadUse = idEx.memRead && idEx.dest != 5'd0 &&
                  (idEx.dest == rs || idEx.dest == rt);
        branchHazard = 1'b0;
        if (isBranch) begin
            if (rs != 5'd0 && ((idEx.regWrite && idEx.dest == rs) ||
                               (memRegWrite && memDest == rs)))
                branchHazard = 1'b1;
            if (rt != 5'd0 && ((idEx.regWrite && idEx.dest == rt) ||
                               (memRegWrite && memDest == rt)))
                branchHazard = 1'b1;
        end
        stall = loadUse || branchHazard;
    end

    assign regStall = stall;
    assign muxStall = stall;

    // Branch/jump resolution; targets wrap modulo 2^32
    always_comb begin
        branchResult = 1'b0;
        branchAddrs  = pcPlus4 + {immExt[29:0], 2'b00};
        if (op == OP_J) branchAddrs = {pcPlus4[31:28], instr[25:0], 2'b00};
        if (!stall) begin
            if (op == OP_BEQ && rsData == rtData) branchResult = 1'b1;
            if (op == OP_BNE && rsData != rtData) branchResult = 1'b1;
            if (op == OP_J)                       branchResult = 1'b1;
        end
    end

    // ID/EX pipeline register; a stall inserts an all-zero bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     idEx <= '0;
        else if (stall) idEx <= '0;
        else            idEx <= dec;
    end

    assign exRegWrite = idEx.regWrite;
    assign exMemRead  = idEx.memRead;
    assign exMemWrite = idEx.memWrite;
    assign exMemToReg = idEx.memToReg;
    assign exAluSrc   = idEx.aluSrc;
    assign exAluCtrl  = idEx.aluCtrl;
    assign exRsData   = idEx.rsData;
    assign exRtData   = idEx.rtData;
    assign exImm      = idEx.imm;
    assign exRs       = idEx.rs;
    assign exRt       = idEx.rt;
    assign exDest     = idEx.dest;
    assign exPc       = idEx.pc;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Directed testbench for instruction_decode_stage with hand-computed expectations.
module tb_instruction_decode_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [63:0] instructionFetchReg;
    logic        wbWrite;
    logic [4:0]  wbAddr;
    logic [31:0] wbData;
    logic        memRegWrite;
    logic [4:0]  memDest;
    logic        branchResult;
    logic [31:0] branchAddrs;
    logic        regStall;
    logic        muxStall;
    logic        exRegWrite, exMemRead, exMemWrite, exMemToReg, exAluSrc;
    logic [2:0]  exAluCtrl;
    logic [31:0] exRsData, exRtData, exImm, exPc;
    logic [4:0]  exRs, exRt, exDest;

    int checks = 0;
    int errors = 0;

    assign instructionFetchReg = {instr, pc};

    instruction_decode_stage dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .instructionFetchReg (instructionFetchReg),
        .wbWrite             (wbWrite),
        .wbAddr              (wbAddr),
        .wbData              (wbData),
        .memRegWrite         (memRegWrite),
        .memDest             (memDest),
        .branchResult        (branchResult),
        .branchAddrs         (branchAddrs),
        .regStall            (regStall),
        .muxStall            (muxStall),
        .exRegWrite          (exRegWrite),
        .exMemRead           (exMemRead),
        .exMemWrite          (exMemWrite),
        .exMemToReg          (exMemToReg),
        .exAluSrc            (exAluSrc),
        .exAluCtrl           (exAluCtrl),
        .exRsData            (exRsData),
        .exRtData            (exRtData),
        .exImm               (exImm),
        .exRs                (exRs),
        .exRt                (exRt),
        .exDest              (exDest),
        .exPc                (exPc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    initial begin
        rst_n = 1'b0; instr = '0; pc = '0;
        wbWrite = 1'b0; wbAddr = '0; wbData = '0;
        memRegWrite = 1'b0; memDest = '0;
        #3;
        checkVal("rst_exRegWrite", 32'(exRegWrite), 32'd0);
        checkVal("rst_exPc", exPc, 32'd0);
        checkVal("rst_regStall", 32'(regStall), 32'd0);
        checkVal("rst_branchResult", 32'(branchResult), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // write-back bypass into add r3,r5,r0
        wbWrite = 1'b1; wbAddr = 5'd5; wbData = 32'hDEADBEEF;
        instr = rType(5'd5, 5'd0, 5'd3, 6'h20); pc = 32'h100;
        tick();
        wbWrite = 1'b0;
        checkVal("byp_exRsData", exRsData, 32'hDEADBEEF);
        checkVal("byp_exDest", 32'(exDest), 32'd3);
        checkVal("byp_exRegWrite", 32'(exRegWrite), 32'd1);
        checkVal("byp_exAluCtrl", 32'(exAluCtrl), 32'd0);
        checkVal("byp_exPc", exPc, 32'h100);

        // r5 now stored; slt r6,r5,r5
        instr = rType(5'd5, 5'd5, 5'd6, 6'h2A);
        tick();
        checkVal("slt_exRtData", exRtData, 32'hDEADBEEF);
        checkVal("slt_exAluCtrl", 32'(exAluCtrl), 32'd4);

        // load r1 = r2 = 7 while sub r0 (dest 0) runs: must not write
        instr = rType(5'd1, 5'd2, 5'd0, 6'h22);
        wbWrite = 1'b1; wbAddr = 5'd1; wbData = 32'd7;
        tick();
        checkVal("sub_r0_exRegWrite", 32'(exRegWrite), 32'd0);
        checkVal("sub_exAluCtrl", 32'(exAluCtrl), 32'd1);
        wbAddr = 5'd2;
        instr = '0;
        tick();
        wbWrite = 1'b0;
        checkVal("nop_exAluSrc", 32'(exAluSrc), 32'd0);

        // sw r2,4(r1)
        instr = iType(6'h2B, 5'd1, 5'd2, 16'h0004); pc = 32'h1F0;
        tick();
        checkVal("sw_exMemWrite", 32'(exMemWrite), 32'd1);
        checkVal("sw_exRegWrite", 32'(exRegWrite), 32'd0);
        checkVal("sw_exImm", exImm, 32'd4);
        checkVal("sw_exRtData", exRtData, 32'd7);

        // addi r3,r1,-1
        instr = iType(6'h08, 5'd1, 5'd3, 16'hFFFF);
        tick();
        checkVal("addi_exImm", exImm, 32'hFFFFFFFF);
        checkVal("addi_exDest", 32'(exDest), 32'd3);
        checkVal("addi_exAluSrc", 32'(exAluSrc), 32'd1);

        // unsupported opcode gives a bubble
        instr = iType(6'h3F, 5'd1, 5'd3, 16'h1234); pc = 32'h1F8;
        tick();
        checkVal("badop_exPc", exPc, 32'd0);
        checkVal("badop_exImm", exImm, 32'd0);

        // load-use: lw r2,0(r1) then add r4,r2,r2
        instr = iType(6'h23, 5'd1, 5'd2, 16'h0000); pc = 32'h200;
        tick();
        checkVal("lw_exMemRead", 32'(exMemRead), 32'd1);
        checkVal("lw_exMemToReg", 32'(exMemToReg), 32'd1);
        checkVal("lw_exDest", 32'(exDest), 32'd2);
        checkVal("lw_exRsData", exRsData, 32'd7);
        instr = rType(5'd2, 5'd2, 5'd4, 6'h20); pc = 32'h204;
        #1;
        checkVal("lu_regStall", 32'(regStall), 32'd1);
        checkVal("lu_muxStall", 32'(muxStall), 32'd1);
        tick();
        checkVal("lu_bubble_exRegWrite", 32'(exRegWrite), 32'd0);
        checkVal("lu_bubble_exMemRead", 32'(exMemRead), 32'd0);
        checkVal("lu_bubble_exPc", exPc, 32'd0);
        checkVal("lu_release_regStall", 32'(regStall), 32'd0);
        tick();
        checkVal("lu_issue_exDest", 32'(exDest), 32'd4);
        checkVal("lu_issue_exPc", exPc, 32'h204);
        checkVal("lu_issue_exRsData", exRsData, 32'd7);

        // beq r1,r2 taken
        instr = iType(6'h04, 5'd1, 5'd2, 16'h0003); pc = 32'h40;
        #1;
        checkVal("beq_branchResult", 32'(branchResult), 32'd1);
        checkVal("beq_branchAddrs", branchAddrs, 32'h50);
        instr = iType(6'h04, 5'd1, 5'd2, 16'hFFFF);
        #1;
        checkVal("beq_neg_branchAddrs", branchAddrs, 32'h40);
        instr = iType(6'h05, 5'd1, 5'd2, 16'h0003);
        #1;
        checkVal("bne_branchResult", 32'(branchResult), 32'd0);

        // jump keeps pc+4 upper nibble
        instr = {6'h02, 26'h0000100}; pc = 32'hF0000010;
        #1;
        checkVal("j_branchResult", 32'(branchResult), 32'd1);
        checkVal("j_branchAddrs", branchAddrs, 32'hF0000400);
        tick();
        checkVal("j_exRegWrite", 32'(exRegWrite), 32'd0);
        checkVal("j_exMemWrite", 32'(exMemWrite), 32'd0);

        // branch hazard against EX/MEM
        memRegWrite = 1'b1; memDest = 5'd1;
        instr = iType(6'h04, 5'd1, 5'd2, 16'h0003); pc = 32'h40;
        #1;
        checkVal("bh_regStall", 32'(regStall), 32'd1);
        checkVal("bh_branchResult", 32'(branchResult), 32'd0);
        tick();
        memRegWrite = 1'b0;
        #1;
        checkVal("bh_bubble_exPc", exPc, 32'd0);
        checkVal("bh_release_regStall", 32'(regStall), 32'd0);
        checkVal("bh_release_branchResult", 32'(branchResult), 32'd1);

        // branch hazard against ID/EX: add r1,r5,r0 then beq r1,r2
        instr = rType(5'd5, 5'd0, 5'd1, 6'h20); pc = 32'h300;
        tick();
        instr = iType(6'h04, 5'd1, 5'd2, 16'h0003); pc = 32'h304;
        #1;
        checkVal("bhex_regStall", 32'(regStall), 32'd1);

        // asynchronous reset mid-stream
        instr = rType(5'd5, 5'd5, 5'd6, 6'h25);
        tick();
        checkVal("or_exAluCtrl", 32'(exAluCtrl), 32'd3);
        rst_n = 1'b0;
        #1;
        checkVal("arst_exRegWrite", 32'(exRegWrite), 32'd0);
        checkVal("arst_exRtData", exRtData, 32'd0);
        checkVal("arst_exAluCtrl", 32'(exAluCtrl), 32'd0);
        instr = '0;
        #1;
        checkVal("arst_regStall", 32'(regStall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        instr = rType(5'd5, 5'd0, 5'd6, 6'h20); pc = 32'h500;
        tick();
        checkVal("arst_r5_exRsData", exRsData, 32'd0);
        checkVal("arst_first_exPc", exPc, 32'h500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_decode_stage.md
Name: instruction_decode_stage

Overview:
- Decode stage that consumes the 64-bit IF/ID register {instruction[63:32], pc[31:0]} from the fetch stage.
- Drives the fetch stage's control inputs: branchResult, branchAddrs, regStall and muxStall.
- Contains the 32x32 register file, branch/jump resolution and hazard detection.
- Launches the ID/EX pipeline register toward execute.

Parameters:
- REG_COUNT, 32, register-file depth; r0 is hard-wired to zero.
- DATA_W, 32, datapath width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- instructionFetchReg  input  64  IF/ID register: [63:32] instruction, [31:0] PC of that instruction
- wbWrite  input  1  write-back enable
- wbAddr  input  5  write-back register
- wbData  input  32  write-back data
- memRegWrite  input  1  instruction in EX/MEM writes a register
- memDest  input  5  EX/MEM destination register
- branchResult  output  1  redirect fetch this cycle (combinational)
- branchAddrs  output  32  redirect target (combinational)
- regStall  output  1  hold IF/ID (combinational)
- muxStall  output  1  hold PC (combinational; always equals regStall)
- exRegWrite, exMemRead, exMemWrite, exMemToReg, exAluSrc  output  1 each  ID/EX control bits
- exAluCtrl  output  3  0=ADD, 1=SUB, 2=AND, 3=OR, 4=SLT
- exRsData, exRtData  output  32  ID/EX operand values
- exImm  output  32  sign-extended immediate
- exRs, exRt, exDest  output  5  ID/EX register numbers
- exPc  output  32  ID/EX PC

Behaviour:
- Decode fields: op = instr[31:26], rs = [25:21], rt = [20:16], rd = [15:11], funct = [5:0], imm = [15:0].
- Supported opcodes:
  - R-type 0x00. funct 0x20 -> ADD, 0x22 -> SUB, 0x24 -> AND, 0x25 -> OR, 0x2A -> SLT. dest = rd.
  - addi 0x08: ADD, AluSrc = 1, dest = rt.
  - lw 0x23: ADD, AluSrc = 1, MemRead = 1, MemToReg = 1, dest = rt.
  - sw 0x2B: ADD, AluSrc = 1, MemWrite = 1, no register write.
  - beq 0x04, bne 0x05, j 0x02: no register write.
- Any other opcode or funct decodes to a bubble (all ex* outputs zero).
- RegWrite is forced to 0 whenever dest == 0. The all-zero instruction is therefore a NOP.
- Register file:
  - Written at the posedge when wbWrite = 1 and wbAddr != 0.
  - Read combinationally, with write-first bypass: if wbWrite = 1 and wbAddr equals the read address (nonzero), the read returns wbData.
  - Reads of r0 always return 0.
- Load-use hazard: exMemRead = 1 and exDest != 0 and exDest matches the current rs or rt -> stall.
- Branch hazard: current op is beq/bne, and rs or rt (nonzero) matches either exDest with exRegWrite = 1 or memDest with memRegWrite = 1 -> stall. No forwarding into ID.
- Stall effects: regStall = muxStall = 1. ID/EX loads the all-zero bubble at the next posedge. branchResult is forced to 0.
- Branch taken condition (only when not stalled): beq with rsData == rtData, bne with rsData != rtData, or j.
- Branch targets:
  - beq/bne: branchAddrs = pc + 4 + (sext(imm) << 2).
  - j: branchAddrs = {pc_plus4[31:28], instr[25:0], 2'b00}.
- Branch arithmetic is mod 2^32; wrap-around is legal.
- branchAddrs is don't-care when branchResult = 0, but it must be driven (no X).
- When a branch is taken, the branch instruction itself is still passed to ID/EX (as a no-op control word). Fetch zeroes IF/ID at that same edge, so the next ID cycle sees a NOP. There is no delay slot.
- Normal operation: ID/EX updates every posedge with the decoded fields and exPc = pc. Latency is 1 cycle from IF/ID to ex* outputs.
- Reset (rst_n = 0, asynchronous): all ex* outputs go to 0 immediately and all 32 registers clear to 0. The combinational outputs then evaluate from the inputs.
- Reset asserted mid-operation discards any in-flight stall with no residual state. Release is synchronous-safe: the first posedge after release performs a normal update.

Test Plan:
- Write-back bypass: wbWrite = 1, wbAddr = 5, wbData = 0xDEADBEEF in the same cycle as IF/ID = add r3,r5,r0 -> next cycle exRsData = 0xDEADBEEF, exDest = 3, exRegWrite = 1, exAluCtrl = 0.
- Load-use stall: lw r2,0(r1) followed by add r4,r2,r2 -> in the add's first ID cycle regStall = muxStall = 1 and the ID/EX bubble is all zeros. The add issues one cycle later.
- Taken beq: r1 = r2 = 7, pc = 0x40, imm = 0x0003 -> branchResult = 1, branchAddrs = 0x50. With imm = 0xFFFF -> branchAddrs = 0x40. bne on the same operands -> branchResult = 0.
- Jump: pc = 0xF0000010, j with target field 0x0000100 -> branchResult = 1, branchAddrs = 0xF0000400.
- Branch hazard: memRegWrite = 1, memDest = 1, then beq r1,r2 -> stall with branchResult = 0. The next cycle, with memRegWrite = 0, the branch resolves normally.
- Reset: pull rst_n low mid-stream -> ex* outputs read 0 without waiting for a clock edge; a subsequent read of r5 returns 0; the stall outputs are 0 for a NOP input.
